// File: rtl/karatsuba_pkg.sv
// Shared types and helpers for the sequential Karatsuba multiplier.
// Imported by karatsuba_mul_seq and karatsuba_half_mul.
package karatsuba_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MHI,
        MLO,
        MMID,
        SUM,
        DONE
    } karatsuba_state_t;

    function automatic int half_w(input int w);
        return w / 2;
    endfunction

endpackage

// File: rtl/karatsuba_half_mul.sv
// Combinational (HALF+1)x(HALF+1) multiplier shared by all three partial products.
// The extra operand bit holds the carry of the middle-term sums.
module karatsuba_half_mul
    import karatsuba_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [half_w(WIDTH):0] x,
    input  logic [half_w(WIDTH):0] y,
    output logic [WIDTH+1:0]       p
);

    localparam int HALF = half_w(WIDTH);

    assign p = {{(HALF + 1){1'b0}}, x} * {{(HALF + 1){1'b0}}, y};

endmodule

// File: rtl/karatsuba_mul_seq.sv
// Sequential Karatsuba multiplier with valid/ready handshakes on both sides.
// Define KARATSUBA_SIGNED_EN to treat operands as two's complement.
module karatsuba_mul_seq
    import karatsuba_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     first_num,
    input  logic [WIDTH-1:0]     second_num,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   solution,
    output logic                 busy
);

    localparam int HALF = half_w(WIDTH);

    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("karatsuba_mul_seq: WIDTH must be even and at least 4");
    end

    karatsuba_state_t   state;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [WIDTH-1:0]   a_in, b_in;
    logic [WIDTH-1:0]   p1, p2;
    logic [WIDTH+1:0]   p3;
    logic [HALF:0]      mul_x, mul_y;
    logic [WIDTH+1:0]   prod;
    logic [WIDTH+1:0]   mid_full;
    logic [2*WIDTH-1:0] mid_ext, result, final_val;
    logic               accept;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

`ifdef KARATSUBA_SIGNED_EN
    logic sign_reg, sign_in;

    // Magnitudes go through the unsigned datapath; the most negative value maps to 2^(WIDTH-1).
    assign a_in      = first_num[WIDTH-1]  ? -first_num  : first_num;
    assign b_in      = second_num[WIDTH-1] ? -second_num : second_num;
    assign sign_in   = first_num[WIDTH-1] ^ second_num[WIDTH-1];
    assign final_val = sign_reg ? -result : result;
`else
    assign a_in      = first_num;
    assign b_in      = second_num;
    assign final_val = result;
`endif

    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state)
            MHI: begin
                mul_x = {1'b0, a_reg[WIDTH-1:HALF]};
                mul_y = {1'b0, b_reg[WIDTH-1:HALF]};
            end
            MLO: begin
                mul_x = {1'b0, a_reg[HALF-1:0]};
                mul_y = {1'b0, b_reg[HALF-1:0]};
            end
            MMID: begin
                mul_x = {1'b0, a_reg[WIDTH-1:HALF]} + {1'b0, a_reg[HALF-1:0]};
                mul_y = {1'b0, b_reg[WIDTH-1:HALF]} + {1'b0, b_reg[HALF-1:0]};
            end
            default: ;
        endcase
    end

    karatsuba_half_mul #(.WIDTH(WIDTH)) u_half_mul (
        .x (mul_x),
        .y (mul_y),
        .p (prod)
    );

    // The middle term is never negative, so the wide zero-extension is exact.
    assign mid_full = p3 - {2'b00, p1} - {2'b00, p2};
    assign mid_ext  = {{(WIDTH - 2){1'b0}}, mid_full};
    assign result   = {p1, {WIDTH{1'b0}}} + (mid_ext << HALF) + {{WIDTH{1'b0}}, p2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            p1        <= '0;
            p2        <= '0;
            p3        <= '0;
            solution  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef KARATSUBA_SIGNED_EN
            sign_reg  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (state == DONE && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                    if (accept) begin
                        a_reg <= a_in;
                        b_reg <= b_in;
`ifdef KARATSUBA_SIGNED_EN
                        sign_reg <= sign_in;
`endif
                        busy  <= 1'b1;
                        state <= MHI;
                    end
                end
                MHI: begin
                    p1    <= prod[WIDTH-1:0];
                    state <= MLO;
                end
                MLO: begin
                    p2    <= prod[WIDTH-1:0];
                    state <= MMID;
                end
                MMID: begin
                    p3    <= prod;
                    state <= SUM;
                end
                SUM: begin
                    solution  <= final_val;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_karatsuba_mul_seq.sv
// Directed self-checking bench for karatsuba_mul_seq (16-bit main instance, 32-bit side instance).
// Expectations follow KARATSUBA_SIGNED_EN when the bench is built with it.
module tb_karatsuba_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] first_num, second_num;
    logic [31:0] solution;

    logic        in_valid32, in_ready32, out_valid32, out_ready32, busy32;
    logic [31:0] first32, second32;
    logic [63:0] solution32;

    int total = 0;
    int bad = 0;
    int cnt;
    logic [31:0] held;

`ifdef KARATSUBA_SIGNED_EN
    localparam logic [31:0] EXP_FF16 = 32'h0000_0001;
    localparam logic [63:0] EXP_FF32 = 64'h0000_0000_0000_0001;
`else
    localparam logic [31:0] EXP_FF16 = 32'hFFFE_0001;
    localparam logic [63:0] EXP_FF32 = 64'hFFFF_FFFE_0000_0001;
`endif

    always #5 clk = ~clk;

    karatsuba_mul_seq #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .first_num  (first_num),
        .second_num (second_num),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .solution   (solution),
        .busy       (busy)
    );

    karatsuba_mul_seq #(.WIDTH(32)) dut32 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid32),
        .in_ready   (in_ready32),
        .first_num  (first32),
        .second_num (second32),
        .out_valid  (out_valid32),
        .out_ready  (out_ready32),
        .solution   (solution32),
        .busy       (busy32)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input bit hold);
        int guard = 0;
        first_num  = a;
        second_num = b;
        in_valid   = 1'b1;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("accept_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic waitValid(input string tag, output int c);
        c = 0;
        while (!out_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        checkOutput(tag, {63'd0, out_valid}, 64'd1);
    endtask

    initial begin
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        first_num   = '0;
        second_num  = '0;
        in_valid32  = 1'b0;
        out_ready32 = 1'b1;
        first32     = '0;
        second32    = '0;

        #2;
        checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_solution", {32'd0, solution}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic product and latency
        applyStimulus(16'd1234, 16'd5678, 1'b0);
        checkOutput("busy_mhi", {63'd0, busy}, 64'd1);
        checkOutput("no_early_valid", {63'd0, out_valid}, 64'd0);
        waitValid("lat1_valid", cnt);
        checkOutput("lat1_cycles", 64'(cnt), 64'd4);
        checkOutput("prod_1234x5678", {32'd0, solution}, 64'h006A_E9BC);
        checkOutput("done_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        checkOutput("pop_clears_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("idle_not_busy", {63'd0, busy}, 64'd0);

        // All-ones operands stress the middle term and carries
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0);
        waitValid("ff16_valid", cnt);
        checkOutput("prod_ffff_sq", {32'd0, solution}, {32'd0, EXP_FF16});
        @(negedge clk);

        checkOutput("w32_ready", {63'd0, in_ready32}, 64'd1);
        first32    = 32'hFFFF_FFFF;
        second32   = 32'hFFFF_FFFF;
        in_valid32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid32 = 1'b0;
        checkOutput("w32_busy", {63'd0, busy32}, 64'd1);
        cnt = 0;
        while (!out_valid32 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("w32_lat", 64'(cnt), 64'd4);
        checkOutput("w32_prod", solution32, EXP_FF32);
        @(negedge clk);

        // Back-to-back with in_valid held high
        applyStimulus(16'd3, 16'd7, 1'b1);
        first_num  = 16'h0100;
        second_num = 16'h0100;
        waitValid("b2b1_valid", cnt);
        checkOutput("b2b1_lat", 64'(cnt), 64'd4);
        checkOutput("b2b1_prod", {32'd0, solution}, 64'd21);
        checkOutput("b2b1_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        checkOutput("b2b_busy", {63'd0, busy}, 64'd1);
        checkOutput("b2b_valid_drop", {63'd0, out_valid}, 64'd0);
        in_valid = 1'b0;
        waitValid("b2b2_valid", cnt);
        checkOutput("b2b2_lat", 64'(cnt), 64'd4);
        checkOutput("b2b2_prod", {32'd0, solution}, 64'h0001_0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("b2b_no_dup", {63'd0, out_valid}, 64'd0);
        end

        // Backpressure: result held, new operands ignored
        out_ready = 1'b0;
        applyStimulus(16'h1234, 16'h0ABC, 1'b0);
        waitValid("bp_valid", cnt);
        checkOutput("bp_prod", {32'd0, solution}, 64'h00C3_6630);
        held = 32'h00C3_6630;
        for (int i = 0; i < 10; i++) begin
            first_num  = 16'(i + 9);
            second_num = 16'(i + 2);
            in_valid   = 1'b1;
            @(negedge clk);
            checkOutput("bp_stable", {32'd0, solution}, {32'd0, held});
            checkOutput("bp_in_ready", {63'd0, in_ready}, 64'd0);
            checkOutput("bp_out_valid", {63'd0, out_valid}, 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        checkOutput("bp_ready_on_pop", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        checkOutput("bp_popped", {63'd0, out_valid}, 64'd0);
        checkOutput("bp_no_accept", {63'd0, busy}, 64'd0);
        checkOutput("bp_value_kept", {32'd0, solution}, {32'd0, held});

        // Reset while in MMID
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("mmid_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("mrst_solution", {32'd0, solution}, 64'd0);
        checkOutput("mrst_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("mrst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("mrst_no_result", {63'd0, out_valid}, 64'd0);
        applyStimulus(16'd2, 16'd3, 1'b0);
        waitValid("after_rst_valid", cnt);
        checkOutput("after_rst_lat", 64'(cnt), 64'd4);
        checkOutput("after_rst_prod", {32'd0, solution}, 64'd6);
        @(negedge clk);

`ifdef KARATSUBA_SIGNED_EN
        applyStimulus(16'hFFFD, 16'd5, 1'b0);
        waitValid("s1_valid", cnt);
        checkOutput("s_m3x5", {32'd0, solution}, 64'hFFFF_FFF1);
        @(negedge clk);
        applyStimulus(16'h8000, 16'h8000, 1'b0);
        waitValid("s2_valid", cnt);
        checkOutput("s_min_sq", {32'd0, solution}, 64'h4000_0000);
        @(negedge clk);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0);
        waitValid("s3_valid", cnt);
        checkOutput("s_m1_sq", {32'd0, solution}, 64'd1);
        @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
